// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// The control unit imports op_t from here for its decode.
package mdu_pkg;

   localparam int MDU_WIDTH   = 8;
   localparam int MDU_LATENCY = MDU_WIDTH + 1;

   typedef enum logic [1:0] {
      MULLO = 2'b00,
      MULHI = 2'b01,
      DIVU  = 2'b10,
      REMU  = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      WB   = 2'b10
   } state_t;

   function automatic logic is_div(input op_t o);
      return (o == DIVU) || (o == REMU);
   endfunction

endpackage

// File: rtl/seq_mul_div.sv
// Iterative unsigned MUL/DIV unit between the register file read ports and its write port.
// One operation takes WIDTH CALC cycles plus one write-back cycle.
module seq_mul_div
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [AW-1:0]    dst,
   output logic             busy,
   output logic             done,
   output logic             dz,
   output logic [WIDTH-1:0] wd3,
   output logic [AW-1:0]    wa3,
   output logic             we3
);

   localparam int CW = $clog2(WIDTH) + 1;

   state_t             state_q, state_d;
   op_t                op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [AW-1:0]      dst_q, dst_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH:0]     rem_q, rem_d;
   logic [WIDTH-1:0]   quo_q, quo_d;

   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               dz_q, dz_d;
   logic               we3_q, we3_d;
   logic [WIDTH-1:0]   wd3_q, wd3_d;
   logic [AW-1:0]      wa3_q, wa3_d;

   logic               last_s;
   logic [WIDTH-1:0]   addend_s;
   logic [WIDTH:0]     sum_s;
   logic [WIDTH+1:0]   trial_s;
   logic [WIDTH+1:0]   diff_s;
   logic [WIDTH-1:0]   result_s;

   assign last_s = (state_q == CALC) && (cnt_q == CW'(WIDTH - 1));

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = CALC;
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            if (last_s) begin
               state_d = WB;
            end else begin
               state_d = CALC;
            end
         end
         WB:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Operand capture, iteration counter and one shift-add / restoring-divide step
   always_comb begin
      op_d   = op_q;
      a_d    = a_q;
      b_d    = b_q;
      dst_d  = dst_q;
      cnt_d  = cnt_q;
      prod_d = prod_q;
      rem_d  = rem_q;
      quo_d  = quo_q;

      if (prod_q[0]) begin
         addend_s = a_q;
      end else begin
         addend_s = {WIDTH{1'b0}};
      end
      sum_s   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, addend_s};
      // A negative trial difference means the divisor does not fit: restore.
      trial_s = {rem_q, quo_q[WIDTH-1]};
      diff_s  = trial_s - {2'b00, b_q};

      if ((state_q == IDLE) && start) begin
         op_d   = op_t'(op);
         a_d    = a;
         b_d    = b;
         dst_d  = dst;
         cnt_d  = {CW{1'b0}};
         prod_d = {{WIDTH{1'b0}}, b};
         rem_d  = {(WIDTH+1){1'b0}};
         quo_d  = a;
      end else if (state_q == CALC) begin
         cnt_d = cnt_q + CW'(1);
         if (is_div(op_q)) begin
            if (diff_s[WIDTH+1]) begin
               rem_d = trial_s[WIDTH:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end else begin
               rem_d = diff_s[WIDTH:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end
         end else begin
            prod_d = {sum_s, prod_q[WIDTH-1:1]};
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q   <= MULLO;
         a_q    <= {WIDTH{1'b0}};
         b_q    <= {WIDTH{1'b0}};
         dst_q  <= {AW{1'b0}};
         cnt_q  <= {CW{1'b0}};
         prod_q <= {(2*WIDTH){1'b0}};
         rem_q  <= {(WIDTH+1){1'b0}};
         quo_q  <= {WIDTH{1'b0}};
      end else begin
         op_q   <= op_d;
         a_q    <= a_d;
         b_q    <= b_d;
         dst_q  <= dst_d;
         cnt_q  <= cnt_d;
         prod_q <= prod_d;
         rem_q  <= rem_d;
         quo_q  <= quo_d;
      end
   end

   // Output next-state; b==0 naturally yields all-ones quotient and remainder=a
   always_comb begin
      case (op_q)
         MULLO:   result_s = prod_d[WIDTH-1:0];
         MULHI:   result_s = prod_d[2*WIDTH-1:WIDTH];
         DIVU:    result_s = quo_d;
         REMU:    result_s = rem_d[WIDTH-1:0];
         default: result_s = {WIDTH{1'b0}};
      endcase

      busy_d = (state_d != IDLE);
      done_d = last_s;
      we3_d  = last_s && (dst_q != {AW{1'b0}});
      dz_d   = last_s && is_div(op_q) && (b_q == {WIDTH{1'b0}});
      if (last_s) begin
         wd3_d = result_s;
         wa3_d = dst_q;
      end else begin
         wd3_d = wd3_q;
         wa3_d = wa3_q;
      end
   end

   // Output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         dz_q   <= 1'b0;
         we3_q  <= 1'b0;
         wd3_q  <= {WIDTH{1'b0}};
         wa3_q  <= {AW{1'b0}};
      end else begin
         busy_q <= busy_d;
         done_q <= done_d;
         dz_q   <= dz_d;
         we3_q  <= we3_d;
         wd3_q  <= wd3_d;
         wa3_q  <= wa3_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign dz   = dz_q;
   assign we3  = we3_q;
   assign wd3  = wd3_q;
   assign wa3  = wa3_q;

endmodule

// File: tb/tb_seq_mul_div.sv
// Self-checking bench for seq_mul_div: cycle-level reference model plus directed literal cases
// and randomized operations with ignored start pulses.
module tb_seq_mul_div;

   localparam int W   = 8;
   localparam int LAT = W + 1;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [1:0] op = 2'b00;
   logic [7:0] a = 8'h00;
   logic [7:0] b = 8'h00;
   logic [2:0] dst = 3'd0;
   logic       busy, done, dz, we3;
   logic [7:0] wd3;
   logic [2:0] wa3;

   int checks = 0;
   int failures = 0;
   logic chk_en = 1'b0;

   seq_mul_div #(.WIDTH(W), .AW(3)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .dst(dst),
      .busy(busy), .done(done), .dz(dz), .wd3(wd3), .wa3(wa3), .we3(we3)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] ref_result(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
      logic [15:0] p;
      p = 16'(x) * 16'(y);
      case (o)
         2'd0:    return p[7:0];
         2'd1:    return p[15:8];
         2'd2:    return (y == 8'd0) ? 8'hFF : x / y;
         default: return (y == 8'd0) ? x : x % y;
      endcase
   endfunction

   // Reference model: countdown of remaining busy cycles, result computed arithmetically at acceptance
   int         m_rem = 0;
   logic [7:0] m_res = 8'h00, m_wd = 8'h00;
   logic [2:0] m_dst = 3'd0, m_wa = 3'd0;
   logic       m_zero = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_we = 1'b0, m_dz = 1'b0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_rem = 0; m_wd = 8'h00; m_wa = 3'd0;
         m_busy = 1'b0; m_done = 1'b0; m_we = 1'b0; m_dz = 1'b0;
      end else begin
         if (m_rem > 0) begin
            m_rem--;
         end else if (start === 1'b1) begin
            m_rem  = LAT;
            m_res  = ref_result(op, a, b);
            m_dst  = dst;
            m_zero = op[1] && (b == 8'd0);
         end
         m_busy = (m_rem > 0);
         m_done = (m_rem == 1);
         m_we   = m_done && (m_dst != 3'd0);
         m_dz   = m_done && m_zero;
         if (m_done) begin
            m_wd = m_res;
            m_wa = m_dst;
         end
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en && rst) begin
         chk("busy", busy, m_busy);
         chk("done", done, m_done);
         chk("we3", we3, m_we);
         chk("dz", dz, m_dz);
         chk("wd3", wd3, m_wd);
         chk("wa3", wa3, m_wa);
      end
   end

   // Register-file write observer
   int         wr_cnt = 0;
   logic [2:0] wr_addr = 3'd0;
   always @(posedge clk) begin
      if (rst && we3) begin
         wr_cnt++;
         wr_addr = wa3;
      end
   end

   int         r_lat, r_lat2, r_bb;
   logic [7:0] r_wd, r_wd2;
   logic [2:0] r_wa;
   logic       r_dz, r_we;

   // Issue one op at the next negedge (cycle 0); optional extra start pulses in cycles p1/p2 (5*6 -> dst 4)
   task automatic do_op(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic [2:0] d, input int p1, input int p2);
      int nk;
      nk = (p2 > 0) ? (2 * LAT + 3) : (LAT + 2);
      r_lat = 0; r_lat2 = 0; r_bb = 0; r_wd = 8'h00; r_wd2 = 8'h00;
      r_wa = 3'd0; r_dz = 1'b0; r_we = 1'b0;
      @(negedge clk);
      op = o; a = x; b = y; dst = d; start = 1'b1;
      for (int k = 1; k <= nk; k++) begin
         @(negedge clk);
         if (k <= LAT + 1 && busy !== (k <= LAT)) r_bb++;
         if (done === 1'b1) begin
            if (r_lat == 0) begin
               r_lat = k; r_wd = wd3; r_wa = wa3; r_dz = dz; r_we = we3;
            end else begin
               r_lat2 = k; r_wd2 = wd3;
            end
         end
         if (k == 1) begin
            start = 1'b0;
            op = 2'($urandom); a = 8'($urandom); b = 8'($urandom); dst = 3'($urandom);
         end
         if (k == p1 || k == p2) begin
            start = 1'b1; op = 2'd0; a = 8'd5; b = 8'd6; dst = 3'd4;
         end else if (k == p1 + 1 || k == p2 + 1) begin
            start = 1'b0;
         end
      end
      start = 1'b0;
   endtask

   task automatic expect_op(input string name, input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                            input logic [2:0] d, input logic [7:0] exp_wd, input logic exp_dz);
      do_op(o, x, y, d, 0, 0);
      chk({name, "_wd3"}, r_wd, exp_wd);
      chk({name, "_dz"}, r_dz, exp_dz);
      chk({name, "_lat"}, r_lat, LAT);
      chk({name, "_wa3"}, r_wa, d);
      chk({name, "_we3"}, r_we, (d != 3'd0));
      chk({name, "_busywin"}, r_bb, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int w0;
      logic [1:0] ro;
      logic [7:0] rx, ry;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_dz", dz, 0);
      chk("rst_we3", we3, 0);
      chk("rst_wd3", wd3, 0);
      chk("rst_wa3", wa3, 0);
      #2 rst = 1'b1;
      chk_en = 1'b1;

      expect_op("mullo13x11", 2'd0, 8'd13, 8'd11, 3'd3, 8'h8F, 1'b0);
      expect_op("mulhi13x11", 2'd1, 8'd13, 8'd11, 3'd3, 8'h00, 1'b0);
      expect_op("mullo_ff",   2'd0, 8'hFF, 8'hFF, 3'd1, 8'h01, 1'b0);
      expect_op("mulhi_ff",   2'd1, 8'hFF, 8'hFF, 3'd1, 8'hFE, 1'b0);
      expect_op("divu200_7",  2'd2, 8'd200, 8'd7, 3'd5, 8'h1C, 1'b0);
      expect_op("remu200_7",  2'd3, 8'd200, 8'd7, 3'd5, 8'h04, 1'b0);
      expect_op("divu_dz",    2'd2, 8'h2A, 8'h00, 3'd2, 8'hFF, 1'b1);
      expect_op("remu_dz",    2'd3, 8'h2A, 8'h00, 3'd2, 8'h2A, 1'b1);

      // dst=0: no write; start in cycle 4 ignored, start in cycle 10 accepted
      w0 = wr_cnt;
      do_op(2'd0, 8'd3, 8'd4, 3'd0, 4, LAT + 1);
      chk("dst0_lat", r_lat, LAT);
      chk("dst0_wd3", r_wd, 8'h0C);
      chk("dst0_we3", r_we, 0);
      chk("dst0_busywin", r_bb, 0);
      chk("next_lat", r_lat2, 2 * LAT + 1);
      chk("next_wd3", r_wd2, 8'h1E);
      chk("dst0_writes", wr_cnt - w0, 1);
      chk("next_waddr", wr_addr, 3'd4);

      // Reset in cycle 5 of a DIVU aborts without a write
      w0 = wr_cnt;
      @(negedge clk);
      op = 2'd2; a = 8'd200; b = 8'd7; dst = 3'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #2 chk_en = 1'b0; rst = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_we3", we3, 0);
      chk("abort_wd3", wd3, 0);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      chk_en = 1'b1;
      chk("abort_writes", wr_cnt - w0, 0);
      expect_op("mullo2x3", 2'd0, 8'd2, 8'd3, 3'd1, 8'h06, 1'b0);
      chk("abort_writes_after", wr_cnt - w0, 1);

      // Randomized operations, some with ignored start pulses while busy
      for (int n = 0; n < 40; n++) begin
         ro = 2'($urandom_range(0, 3));
         rx = 8'($urandom);
         ry = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
         do_op(ro, rx, ry, 3'($urandom), ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, LAT)) : 0, 0);
         chk("rand_lat", r_lat, LAT);
         chk("rand_wd3", r_wd, ref_result(ro, rx, ry));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seq_mul_div.md
# seq_mul_div

Iterative unsigned multiply/divide unit that sits directly downstream of the 8×8-bit register file's read ports, rd1/rd2. It writes its result back through the register file's write port: wd3, wa3 and we3. The control unit issues one operation with a single-cycle `start`. The block latches the operands, runs a shift-add or restoring-division loop for WIDTH cycles, then performs one write-back cycle. This adds MUL/DIV/REM to the datapath without a combinational multiplier or divider.

## Interface
- WIDTH, 8: operand/result width in bits.
- AW, 3: register address width.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  issue request; sampled only in IDLE.
- op  in  2  00 MULLO, 01 MULHI, 10 DIVU (quotient), 11 REMU (remainder).
- a  in  WIDTH  operand A / dividend (from rd1).
- b  in  WIDTH  operand B / divisor (from rd2).
- dst  in  AW  destination register address.
- busy  out  1  operation in progress (CALC or WB).
- done  out  1  one-cycle pulse in the write-back cycle.
- dz  out  1  divide-by-zero flag; pulses with done for DIVU/REMU when b==0.
- wd3  out  WIDTH  write data to register file.
- wa3  out  AW  write address to register file.
- we3  out  1  write enable to register file; one-cycle pulse.

## Operation
- States:
  - IDLE: start=1 latches op, a, b and dst into internal registers, clears the iteration counter and goes to CALC.
  - CALC: runs exactly WIDTH iterations, then goes to WB.
  - WB: lasts one cycle and returns unconditionally to IDLE.
- Multiply uses shift-add into a 2·WIDTH product register.
  - MULLO returns product[WIDTH-1:0].
  - MULHI returns product[2·WIDTH-1:WIDTH].
- Divide is restoring, with a WIDTH+1-bit partial remainder.
  - DIVU returns the quotient.
  - REMU returns the remainder.
- Divide by zero (b==0 latched):
  - DIVU result is all ones; REMU result is a.
  - dz=1 in the WB cycle.
  - Latency is unchanged.
- All arithmetic is unsigned with no overflow flag; MULLO discards the high half.
- WB cycle: done=1, wd3=result, wa3=dst, and we3=1 only if dst!=0, since $0 is never written.
- start while busy=1 is ignored, with no queuing. a, b, op and dst are don't-care after the acceptance cycle.
- Reset mid-operation aborts immediately: no write-back occurs, the state returns to IDLE and all outputs are cleared.

## Timing
- Reset values: busy=0, done=0, dz=0, we3=0, wd3=0, wa3=0, state IDLE, counter 0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Cycle numbering: start is high in cycle 0 while in IDLE.
  - busy is high in cycles 1..WIDTH+1.
  - CALC occupies cycles 1..WIDTH.
  - done, we3 and dz are valid in cycle WIDTH+1 (cycle 9 for WIDTH=8).
- Earliest next acceptance is cycle WIDTH+2, with a throughput of one op per WIDTH+2 cycles.
- wd3 and wa3 hold their last write-back values until the next WB. we3, done and dz are high for exactly one cycle.
- The register file captures wd3 on the rising edge that ends the WB cycle.

## Structure
- Shared package mdu_pkg:
  - op_t enum: MULLO, MULHI, DIVU, REMU.
  - state_t enum: IDLE, CALC, WB.
  - Constant MDU_LATENCY = WIDTH+1.
- The control unit imports op_t from mdu_pkg for its decode.
- Single module with no sub-module. FSM, counter and datapath are about 150–250 lines.
- Counter width is $clog2(WIDTH)+1.

## Test plan
- MULLO/MULHI with a=13, b=11, dst=3:
  - MULLO: wd3=0x8F, wa3=3, we3 pulse in cycle 9.
  - MULHI: wd3=0x00.
- MULLO/MULHI with a=0xFF, b=0xFF: MULLO gives 0x01, MULHI gives 0xFE. busy is high in cycles 1–9 and low in cycle 10.
- DIVU/REMU with a=200, b=7, dst=5: DIVU gives wd3=0x1C, REMU gives wd3=0x04, dz=0 in both cases.
- Divide by zero with a=0x2A, b=0:
  - DIVU: wd3=0xFF, dz=1 with done.
  - REMU: wd3=0x2A, dz=1.
- dst=0, MULLO 3×4: done pulses in cycle 9 with we3=0 throughout. A start pulse in cycle 4 is ignored, and the next start in cycle 10 is accepted.
- rst low in cycle 5 of a DIVU:
  - busy, done and we3 go to 0 immediately and no write occurs.
  - After release, a fresh MULLO 2×3 returns 0x06.
